// File: rtl/xm_mem_responder.sv
// Single-outstanding memory responder for the XM core: one request per idle cycle,
// serviced against a word-organised RAM after WAIT wait states.
module xm_mem_responder #(
    parameter int WORD   = 16,
    parameter int MEM_AW = 10,
    parameter int WAIT   = 2
) (
    input  logic            clk_i,
    input  logic            arst_i,
    input  logic            memEn_i,
    input  logic            memRW_i,
    input  logic            byteOp_i,
    input  logic [WORD-1:0] addr_i,
    input  logic [WORD-1:0] wrData_i,
    output logic            memBusy_o,
    output logic            memWr_o,
    output logic [WORD-1:0] rdData_o,
    output logic            alignErr_o
);

    typedef enum logic {IDLE, SERVE} state_t;

    // Only the address bits that reach the RAM are kept; upper bits alias away.
    typedef struct packed {
        logic              rw;
        logic              byte_op;
        logic [MEM_AW:0]   addr;
        logic [WORD-1:0]   wdata;
    } req_t;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    req_t              req, req_nxt;
    logic              busy_nxt, wr_nxt, err_nxt;
    logic [WORD-1:0]   rd_nxt;
    logic              mem_we;
    logic [WORD-1:0]   mem_wdata;
    logic [MEM_AW-1:0] idx;
    logic [WORD-1:0]   ram_q;
    logic [WORD-1:0]   mem [2**MEM_AW];
    logic              unused_addr_hi;

    assign unused_addr_hi = ^addr_i[WORD-1:MEM_AW+1];
    assign idx            = req.addr[MEM_AW:1];
    assign ram_q          = mem[idx];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_nxt   = req;
        busy_nxt  = memBusy_o;
        wr_nxt    = 1'b0;
        err_nxt   = 1'b0;
        rd_nxt    = rdData_o;
        mem_we    = 1'b0;
        mem_wdata = ram_q;
        case (state)
            IDLE: begin
                if (memEn_i) begin
                    req_nxt.rw      = memRW_i;
                    req_nxt.byte_op = byteOp_i;
                    req_nxt.addr    = addr_i[MEM_AW:0];
                    req_nxt.wdata   = wrData_i;
                    // Misaligned word access is flagged but still serviced on the aligned word.
                    if (!byteOp_i) begin
                        req_nxt.addr[0] = 1'b0;
                        err_nxt         = addr_i[0];
                    end
                    cnt_nxt   = WAIT_CNT;
                    busy_nxt  = 1'b1;
                    state_nxt = SERVE;
                end
            end
            SERVE: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                    if (req.rw) begin
                        mem_we = 1'b1;
                        if (!req.byte_op)
                            mem_wdata = req.wdata;
                        else if (req.addr[0])
                            mem_wdata[15:8] = req.wdata[7:0];
                        else
                            mem_wdata[7:0] = req.wdata[7:0];
                    end else begin
                        wr_nxt = 1'b1;
                        if (!req.byte_op)
                            rd_nxt = ram_q;
                        else if (req.addr[0])
                            rd_nxt = {{(WORD-8){1'b0}}, ram_q[15:8]};
                        else
                            rd_nxt = {{(WORD-8){1'b0}}, ram_q[7:0]};
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!arst_i) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            req        <= '0;
            memBusy_o  <= 1'b0;
            memWr_o    <= 1'b0;
            rdData_o   <= '0;
            alignErr_o <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            req        <= req_nxt;
            memBusy_o  <= busy_nxt;
            memWr_o    <= wr_nxt;
            rdData_o   <= rd_nxt;
            alignErr_o <= err_nxt;
        end
    end

    // RAM has no reset; a reset on the completion edge suppresses the commit.
    always_ff @(posedge clk_i) begin
        if (arst_i && mem_we)
            mem[idx] <= mem_wdata;
    end

endmodule

// File: tb/tb_xm_mem_responder.sv
// Scoreboard bench for xm_mem_responder: reads push expected data, a monitor checks memWr strobes.
module tb_xm_mem_responder;

    localparam int WAIT = 2;

    logic        clk, arst, memEn, memRW, byteOp;
    logic [15:0] addr, wrData;
    logic        memBusy, memWr, alignErr;
    logic [15:0] rdData;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];

    xm_mem_responder #(.WORD(16), .MEM_AW(10), .WAIT(WAIT)) dut (
        .clk_i      (clk),
        .arst_i     (arst),
        .memEn_i    (memEn),
        .memRW_i    (memRW),
        .byteOp_i   (byteOp),
        .addr_i     (addr),
        .wrData_i   (wrData),
        .memBusy_o  (memBusy),
        .memWr_o    (memWr),
        .rdData_o   (rdData),
        .alignErr_o (alignErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every memWr strobe must match the oldest outstanding read.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (memWr === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_memWr: got rdData %h expected no strobe", rdData);
                end else begin
                    e = exp_q.pop_front();
                    check("rdData", rdData, e);
                end
            end
        end
    end

    // Issue one request at the current negedge; returns at the negedge of the completion cycle.
    task automatic req(input logic rw, input logic bo, input logic [15:0] a, input logic [15:0] wd,
                       input logic [15:0] exp_rd, input logic exp_err, input logic intrude);
        int b;
        if (!rw) exp_q.push_back(exp_rd);
        memEn = 1'b1; memRW = rw; byteOp = bo; addr = a; wrData = wd;
        @(negedge clk);
        check("alignErr", {15'd0, alignErr}, {15'd0, exp_err});
        if (intrude) begin
            memEn = 1'b1; memRW = 1'b1; byteOp = 1'b0; addr = 16'h0030; wrData = 16'hDEAD;
        end else begin
            memEn = 1'b0;
        end
        b = 0;
        while (memBusy === 1'b1 && b < 40) begin
            b++;
            @(negedge clk);
            memEn = 1'b0;
            if (b == 1) check("alignErr_clear", {15'd0, alignErr}, 16'd0);
        end
        check("busy_len", 16'(b), 16'(WAIT + 1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        arst = 1'b0; memEn = 1'b0; memRW = 1'b0; byteOp = 1'b0; addr = '0; wrData = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {15'd0, memBusy}, 16'd0);
        check("rst_memWr", {15'd0, memWr}, 16'd0);
        check("rst_rdData", rdData, 16'h0000);
        check("rst_alignErr", {15'd0, alignErr}, 16'd0);
        arst = 1'b1;
        @(negedge clk);

        // word read
        req(1'b1, 1'b0, 16'h0008, 16'hBEEF, 16'h0, 1'b0, 1'b0);
        req(1'b0, 1'b0, 16'h0008, 16'h0,    16'hBEEF, 1'b0, 1'b0);

        // byte write then read
        req(1'b1, 1'b0, 16'h0010, 16'h1234, 16'h0, 1'b0, 1'b0);
        req(1'b1, 1'b1, 16'h0011, 16'h00AB, 16'h0, 1'b0, 1'b0);
        req(1'b0, 1'b0, 16'h0010, 16'h0,    16'hAB34, 1'b0, 1'b0);
        req(1'b0, 1'b1, 16'h0010, 16'h0,    16'h0034, 1'b0, 1'b0);
        req(1'b0, 1'b1, 16'h0011, 16'h0,    16'h00AB, 1'b0, 1'b0);

        // misaligned word write, then low-lane byte write into the same word
        req(1'b1, 1'b0, 16'h0021, 16'h5555, 16'h0, 1'b1, 1'b0);
        req(1'b0, 1'b0, 16'h0020, 16'h0,    16'h5555, 1'b0, 1'b0);
        req(1'b1, 1'b1, 16'h0020, 16'h99CD, 16'h0, 1'b0, 1'b0);
        req(1'b0, 1'b0, 16'h0020, 16'h0,    16'h55CD, 1'b0, 1'b0);

        // request while busy is dropped
        req(1'b1, 1'b0, 16'h0030, 16'h7777, 16'h0, 1'b0, 1'b0);
        req(1'b0, 1'b0, 16'h0008, 16'h0,    16'hBEEF, 1'b0, 1'b1);
        req(1'b0, 1'b0, 16'h0030, 16'h0,    16'h7777, 1'b0, 1'b0);

        // reset mid-write abandons the write
        req(1'b1, 1'b0, 16'h0040, 16'h1111, 16'h0, 1'b0, 1'b0);
        memEn = 1'b1; memRW = 1'b1; byteOp = 1'b0; addr = 16'h0040; wrData = 16'h0F0F;
        @(negedge clk);
        memEn = 1'b0;
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", {15'd0, memBusy}, 16'd0);
        check("mid_rst_memWr", {15'd0, memWr}, 16'd0);
        check("mid_rst_rdData", rdData, 16'h0000);
        check("mid_rst_alignErr", {15'd0, alignErr}, 16'd0);
        arst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", {15'd0, memBusy}, 16'd0);
        req(1'b0, 1'b0, 16'h0040, 16'h0, 16'h1111, 1'b0, 1'b0);

        // back-to-back with aliasing above the RAM size
        req(1'b1, 1'b0, 16'h0000, 16'hC0DE, 16'h0, 1'b0, 1'b0);
        req(1'b0, 1'b0, 16'h0800, 16'h0,    16'hC0DE, 1'b0, 1'b0);
        req(1'b1, 1'b0, 16'h0802, 16'h2468, 16'h0, 1'b0, 1'b0);
        req(1'b0, 1'b0, 16'h0002, 16'h0,    16'h2468, 1'b0, 1'b0);
        req(1'b0, 1'b1, 16'hF803, 16'h0,    16'h0024, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        check("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/xm_mem_responder.md
# xm_mem_responder

Memory-side responder for the XM core's single-outstanding memory request interface. It accepts the one-cycle request pulse issued by the core controller (`memEn`/`memRW`/`byteOp` plus address and write data) and services it against an internal word-organised RAM after a programmable number of wait states. It reports progress back through `memBusy` and a one-cycle `memWr` read-data strobe. It sits between the core datapath and on-chip instruction/data storage, and is the target of every FETCH, ACC_LOAD/STORE and REL_LOAD/STORE access.

## Interface
- `WORD`, 16: data and address width in bits.
- `MEM_AW`, 10: RAM word-address width; depth is 2**MEM_AW words.
- `WAIT`, 2: extra wait cycles per access, 0..15.

- `clk_i`  in  1  clock; all logic on rising edge.
- `arst_i`  in  1  reset; synchronous, active-low.
- `memEn_i`  in  1  request strobe; one request per cycle it is sampled high while idle.
- `memRW_i`  in  1  0 = read, 1 = write; sampled with `memEn_i`.
- `byteOp_i`  in  1  1 = byte access, 0 = word access.
- `addr_i`  in  WORD  byte address.
- `wrData_i`  in  WORD  write data; byte writes use bits [7:0].
- `memBusy_o`  out  1  high while a request is in service.
- `memWr_o`  out  1  one-cycle pulse: `rdData_o` is valid (reads only).
- `rdData_o`  out  WORD  read data; holds until the next read completes.
- `alignErr_o`  out  1  one-cycle pulse on a misaligned word request.

## Operation
- The state machine has two states, IDLE and SERVE. A wait counter `cnt` is 4 bits wide.
- **IDLE.** When `memEn_i` = 1 at an edge:
  - Latch `memRW_i`, `byteOp_i`, `addr_i` and `wrData_i`.
  - Set `cnt` to WAIT, set `memBusy_o` to 1 and go to SERVE.
  - A word request with `addr_i[0]` = 1 also pulses `alignErr_o`. The access proceeds with bit 0 forced to 0.
- **SERVE, `cnt` ≠ 0.** Decrement `cnt`.
- **SERVE, `cnt` = 0.** Perform the access, then clear `memBusy_o` and return to IDLE.
  - Word index is `addr[MEM_AW:1]`. Higher address bits are ignored, so accesses alias (wrap) modulo the RAM size.
  - Word read: `rdData_o` = RAM word, and `memWr_o` pulses.
  - Byte read: `rdData_o` = {8'h00, selected byte}, and `memWr_o` pulses. `addr[0]` = 0 selects bits [7:0]; `addr[0]` = 1 selects bits [15:8].
  - Word write: the whole word is replaced.
  - Byte write: only the lane selected by `addr[0]` is replaced with `wrData[7:0]`; the other lane is unchanged.
  - Writes never pulse `memWr_o`.
- `memEn_i` is ignored while in SERVE. No queueing is done and no error is flagged.
- A new request is accepted in IDLE on the same edge at which the previous `memWr_o` pulse ends. Back-to-back accesses are therefore legal.
- RAM contents are not initialised or cleared by reset.

## Timing
- **Reset values:** `memBusy_o` = 0, `memWr_o` = 0, `rdData_o` = 0, `alignErr_o` = 0, state = IDLE, `cnt` = 0.
- **Request edge.** Call the rising edge that samples `memEn_i` = 1 edge N. `memBusy_o` is registered high after edge N and stays high for WAIT+1 cycles.
- **Completion edge.** The access completes at edge N+1+WAIT.
  - After that edge, `memBusy_o` = 0 and, for a read, `memWr_o` = 1 for exactly one cycle with `rdData_o` valid.
  - A write is committed to the RAM at that same edge.
- **Alignment error.** `alignErr_o` is high for the cycle after edge N only.
- **Interaction with the core.** The core controller advances on the falling edge. It therefore observes `memBusy_o` high in the state following the request. It observes `memBusy_o` low together with `memWr_o` in the completion cycle.
- **Reset during SERVE** (`arst_i` low at any edge): the pending access is abandoned. A write whose completion edge has not yet occurred is not committed. No `memWr_o` pulse is issued.
- **Reset at the completion edge:** reset wins. No write is committed and no pulse is issued.

## Test plan
- **Word read, WAIT=2.** Preload word 0x0004 = 16'hBEEF. Pulse a read to `addr_i` = 16'h0008 at edge N.
  - `memBusy_o` is high for 3 cycles.
  - `memWr_o` pulses after edge N+3 with `rdData_o` = 16'hBEEF.
- **Byte write then read.** Write word 16'h1234 to 16'h0010, then byte-write 8'hAB to 16'h0011, then word-read 16'h0010.
  - The read returns 16'hAB34.
  - A byte read of 16'h0010 returns 16'h0034.
- **Misaligned word write.** Word-write 16'h5555 to 16'h0021.
  - `alignErr_o` pulses once.
  - A subsequent read of 16'h0020 returns 16'h5555.
- **Request while busy (WAIT=3).** Assert `memEn_i` again at edge N+1 with a write to 16'h0030.
  - That request is ignored and word 16'h0030 is unchanged.
  - The first access completes at edge N+4.
- **Reset mid-write.** Start a write of 16'h0F0F to 16'h0040 with WAIT=3, then drive `arst_i` low at edge N+2.
  - All outputs read 0.
  - The word keeps its previous value.
- **Back-to-back reads, WAIT=0, and aliasing.** Issue a new read in each cycle `memBusy_o` = 0.
  - Each read completes 1 cycle after acceptance.
  - `memWr_o` pulses alternate with busy cycles.
  - `addr_i` = 16'h0800 aliases to word 0 (MEM_AW=10).
